write_back_buffered: RTL

//  Parametrised successor to the single-cycle write-back stage. Accepts completed

---
 rtl/write_back_buffered.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/write_back_buffered.sv
// write_back_buffered
//   Buffered write-back stage. MEM results enter an in-order FIFO of BUF_DEPTH
//   entries. Register-file and CSR write values are decoded when an entry is
//   written into the FIFO. The head entry retires at most once per cycle to the
//   register file and the CSR file.
//   Also produces a registered PC redirect pulse and a pending-rd mask for decode.
//
//   Optional feature macro: WB_INSTRET_EN. When it is defined, instret is a
//   64-bit retire counter. When it is undefined, instret is tied to zero.
//
//   Select encodings:
//     in_wb_sel : 0 RI_TYPE_LUI, 1 LOAD, 2 JUMP, 3 ZICSR, 4 WB_MRET, 5..7 other
//     in_pc_sel : 0 PC_NEXT, 1 PC_BRANCH, 2 PC_MRET, 3 treated as PC_NEXT
//
//   Handshake: a transfer happens on a rising edge where in_valid && in_ready.
//   in_ready depends only on buffer occupancy and never on in_valid. The producer
//   holds its payload stable while in_valid is high and in_ready is low. There is
//   no pass-through path, so a full buffer rejects input even when the head is
//   retiring in the same cycle.
module write_back_buffered #(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_wb_sel,
   input  logic [1:0]       in_pc_sel,
   input  logic [XLEN-1:0]  in_pc_plus_4,
   input  logic [XLEN-1:0]  in_pc_branch,
   input  logic [XLEN-1:0]  in_pc_mepc,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_read_data,
   input  logic [1:0]       in_load_size,
   input  logic             in_load_unsigned,
   input  logic [4:0]       in_rd,
   input  logic [11:0]      in_csr_addr,
   input  logic [XLEN-1:0]  in_csr_data,
   input  logic             csr_ready,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             csr_we,
   output logic [11:0]      csr_waddr,
   output logic [XLEN-1:0]  csr_wdata,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [31:0]      pending_rd,
   output logic [63:0]      instret
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] WB_LUI   = 3'd0;
   localparam logic [2:0] WB_LOAD  = 3'd1;
   localparam logic [2:0] WB_JUMP  = 3'd2;
   localparam logic [2:0] WB_ZICSR = 3'd3;
   localparam logic [2:0] WB_MRET  = 3'd4;

   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_MRET   = 2'd2;

   // FIFO storage, one slot per buffered instruction
   logic [BUF_DEPTH-1:0] ent_valid;
   logic [BUF_DEPTH-1:0] ent_rf_we;
   logic [BUF_DEPTH-1:0] ent_csr_we;
   logic [4:0]           ent_rd       [BUF_DEPTH];
   logic [XLEN-1:0]      ent_rf_data  [BUF_DEPTH];
   logic [11:0]          ent_csr_addr [BUF_DEPTH];
   logic [XLEN-1:0]      ent_csr_data [BUF_DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic            enq;
   logic            retire;
   logic [XLEN-1:0] load_ext;
   logic            dec_rf_we;
   logic [XLEN-1:0] dec_rf_data;
   logic            dec_csr_we;

   assign in_ready = (count < CW'(BUF_DEPTH));
   assign enq      = in_valid && in_ready;
   // A head entry with a CSR write that is blocked also holds back its rf write.
   // This keeps the two writes of one entry in the same cycle.
   assign retire   = (count != '0) && (!ent_csr_we[rd_ptr] || csr_ready);

   // Narrow the raw load data and extend it to XLEN (size 3 behaves as word)
   always_comb begin
      load_ext = in_read_data;
      case (in_load_size)
         2'd0: load_ext = {{(XLEN-8){in_read_data[7] & ~in_load_unsigned}}, in_read_data[7:0]};
         2'd1: load_ext = {{(XLEN-16){in_read_data[15] & ~in_load_unsigned}}, in_read_data[15:0]};
         default: load_ext = in_read_data;
      endcase
   end

   // Decode the write-back selector into the stored rf/csr write values
   always_comb begin
      dec_rf_we   = 1'b0;
      dec_rf_data = in_alu_result;
      dec_csr_we  = 1'b0;
      case (in_wb_sel)
         WB_LUI:   begin dec_rf_we = 1'b1; dec_rf_data = in_alu_result; end
         WB_LOAD:  begin dec_rf_we = 1'b1; dec_rf_data = load_ext;      end
         WB_JUMP:  begin dec_rf_we = 1'b1; dec_rf_data = in_pc_plus_4;  end
         WB_ZICSR: begin dec_rf_we = 1'b1; dec_rf_data = in_csr_data; dec_csr_we = 1'b1; end
         WB_MRET:  begin dec_csr_we = 1'b1; end
         default:  begin dec_rf_we = 1'b0; end
      endcase
      // x0 is never written, so it never appears in pending_rd either
      if (in_rd == 5'd0) dec_rf_we = 1'b0;
   end

   // FIFO pointers, occupancy and entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ent_valid  <= '0;
         ent_rf_we  <= '0;
         ent_csr_we <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            ent_rd[i]       <= '0;
            ent_rf_data[i]  <= '0;
            ent_csr_addr[i] <= '0;
            ent_csr_data[i] <= '0;
         end
      end else begin
         // Write and read slots only coincide when the buffer is empty or full.
         // In those cases only one of enq/retire can be active.
         if (retire) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (enq) begin
            ent_valid[wr_ptr]    <= 1'b1;
            ent_rf_we[wr_ptr]    <= dec_rf_we;
            ent_csr_we[wr_ptr]   <= dec_csr_we;
            ent_rd[wr_ptr]       <= in_rd;
            ent_rf_data[wr_ptr]  <= dec_rf_data;
            ent_csr_addr[wr_ptr] <= in_csr_addr;
            ent_csr_data[wr_ptr] <= in_alu_result;
            wr_ptr               <= wr_ptr + PW'(1);
         end
         case ({enq, retire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Retire-side write ports, driven by the head entry when it retires
   always_comb begin
      rf_we     = retire && ent_rf_we[rd_ptr];
      csr_we    = retire && ent_csr_we[rd_ptr];
      rf_waddr  = rf_we  ? ent_rd[rd_ptr]       : '0;
      rf_wdata  = rf_we  ? ent_rf_data[rd_ptr]  : '0;
      csr_waddr = csr_we ? ent_csr_addr[rd_ptr] : '0;
      csr_wdata = csr_we ? ent_csr_data[rd_ptr] : '0;
   end

   // Scoreboard mask of destination registers still held in the buffer
   always_comb begin
      pending_rd = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (ent_valid[i] && ent_rf_we[i]) pending_rd[ent_rd[i]] = 1'b1;
      end
   end

   // Redirect pulse for the cycle after a taken branch or MRET is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= 1'b0;
         if (enq && (in_pc_sel == PC_BRANCH) && in_alu_result[0]) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= in_pc_branch;
         end else if (enq && (in_pc_sel == PC_MRET)) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= in_pc_mepc;
         end
      end
   end

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;

   // Count every retired entry, including ones that write nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) instret_q <= '0;
      else if (retire) instret_q <= instret_q + 64'd1;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule
